ps_head_inserter: RTL and testbench



---
 rtl/ps_head_inserter.sv | 136 +++++++++++++
 tb/tb_ps_head_inserter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_head_inserter.sv
// Prepends a parallel header (serialised word 0 first) to each payload packet.
// Define PS_HEAD_INSERTER_OUTREG_EN to register the output through a two-entry skid stage.
module ps_head_inserter #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [LENGTH-1:0][WIDTH-1:0]   i_hdr,
    input  logic [$clog2(LENGTH)-1:0]      i_len,
    input  logic                           i_hval,
    output logic                           i_hrdy,
    input  logic [WIDTH-1:0]               i_dat,
    input  logic                           i_val,
    input  logic                           i_eop,
    output logic                           i_rdy,
    output logic [WIDTH-1:0]               o_dat,
    output logic                           o_val,
    output logic                           o_eop,
    input  logic                           o_rdy
);
    localparam int LW = $clog2(LENGTH);

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t                         state_q, state_d;
    logic [LENGTH-1:0][WIDTH-1:0]   hdr_q, hdr_d;
    logic [LW-1:0]                  len_q, len_d;
    logic [LW-1:0]                  hcnt_q, hcnt_d;

    logic [WIDTH-1:0]               c_dat;
    logic                           c_val, c_eop, c_rdy;
    logic                           hrdy_c, rdy_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            len_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            len_q   <= len_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        len_d   = len_q;
        hcnt_d  = hcnt_q;
        c_dat   = '0;
        c_val   = 1'b0;
        c_eop   = 1'b0;
        hrdy_c  = 1'b0;
        rdy_c   = 1'b0;
        case (state_q)
            IDLE: begin
                hrdy_c = 1'b1;
                if (i_hval) begin
                    hdr_d   = i_hdr;
                    len_d   = i_len;
                    hcnt_d  = '0;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                c_val = 1'b1;
                c_dat = hdr_q[0];
                if (c_rdy) begin
                    hdr_d  = {{WIDTH{1'b0}}, hdr_q[LENGTH-1:1]};
                    hcnt_d = hcnt_q + 1'b1;
                    if (hcnt_q == len_q)
                        state_d = BODY;
                end
            end
            BODY: begin
                c_dat = i_dat;
                c_val = i_val;
                c_eop = i_eop;
                rdy_c = c_rdy;
                if (i_val && c_rdy && i_eop)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign i_hrdy = hrdy_c & ~reset;
    assign i_rdy  = rdy_c & ~reset;

`ifdef PS_HEAD_INSERTER_OUTREG_EN
    logic [WIDTH-1:0] od_q, sd_q;
    logic             ov_q, oe_q, sv_q, se_q;

    // Core readiness depends only on skid occupancy, breaking the o_rdy -> i_rdy path.
    assign c_rdy = ~sv_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            od_q <= '0;
            ov_q <= 1'b0;
            oe_q <= 1'b0;
            sd_q <= '0;
            sv_q <= 1'b0;
            se_q <= 1'b0;
        end else if (o_rdy || !ov_q) begin
            if (sv_q) begin
                od_q <= sd_q;
                oe_q <= se_q;
                ov_q <= 1'b1;
                sv_q <= 1'b0;
            end else begin
                od_q <= c_dat;
                oe_q <= c_eop;
                ov_q <= c_val;
            end
        end else if (c_val && c_rdy) begin
            sd_q <= c_dat;
            se_q <= c_eop;
            sv_q <= 1'b1;
        end
    end

    assign o_dat = reset ? '0 : od_q;
    assign o_val = ov_q & ~reset;
    assign o_eop = oe_q & ~reset;
`else
    assign c_rdy = o_rdy;
    assign o_dat = reset ? '0 : c_dat;
    assign o_val = c_val & ~reset;
    assign o_eop = c_eop & ~reset;
`endif
endmodule

// File: tb/tb_ps_head_inserter.sv
// Scoreboard bench for ps_head_inserter: expected word stream built from packet descriptions.
module tb_ps_head_inserter;
    localparam int W  = 8;
    localparam int L  = 4;
    localparam int LW = $clog2(L);
`ifdef PS_HEAD_INSERTER_OUTREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [L-1:0][W-1:0] hdr;
        logic [LW-1:0]       len;
    } hdr_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [L-1:0][W-1:0] i_hdr = '0;
    logic [LW-1:0]       i_len = '0;
    logic                i_hval = 1'b0;
    logic                i_hrdy;
    logic [W-1:0]        i_dat = '0;
    logic                i_val = 1'b0;
    logic                i_eop = 1'b0;
    logic                i_rdy;
    logic [W-1:0]        o_dat;
    logic                o_val;
    logic                o_eop;
    logic                o_rdy = 1'b0;

    ps_head_inserter #(.WIDTH(W), .LENGTH(L)) dut (
        .clk(clk), .reset(reset),
        .i_hdr(i_hdr), .i_len(i_len), .i_hval(i_hval), .i_hrdy(i_hrdy),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
        .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    hdr_t        hq[$];
    logic [W:0]  pq[$];
    logic [W:0]  exp_q[$];
    int          out_cyc[$], hacc_q[$], pacc_q[$], peop_q[$];

    logic        hs_h = 1'b0, hs_p = 1'b0;
    logic        h_on = 1'b0, p_on = 1'b0;
    int          hprob = 100, pprob = 100, ordy_mode = 0, pat_i = 0;
    logic        prev_stall = 1'b0;
    logic [W-1:0] prev_dat;
    logic        prev_eop;
    bit          pat [6] = '{1, 0, 0, 1, 0, 1};

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares each output transfer with the scoreboard and logs handshake cycles.
    always @(negedge clk) begin
        int lbl;
        logic [W:0] e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            lbl = cyc + 1;
            if (prev_stall) begin
                checks++;
                if (!(o_val && o_dat == prev_dat && o_eop == prev_eop)) begin
                    errors++;
                    $display("FAIL hold actual val=%0b dat=%0h eop=%0b expected val=1 dat=%0h eop=%0b",
                             o_val, o_dat, o_eop, prev_dat, prev_eop);
                end
            end
            if (o_val && o_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word actual %0h/%0b expected none", o_dat, o_eop);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_eop, o_dat} !== e) begin
                        errors++;
                        $display("FAIL word actual dat=%0h eop=%0b expected dat=%0h eop=%0b",
                                 o_dat, o_eop, e[W-1:0], e[W]);
                    end
                end
                out_cyc.push_back(lbl);
            end
            hs_h = i_hval && i_hrdy;
            if (hs_h) hacc_q.push_back(lbl);
            hs_p = i_val && i_rdy;
            if (hs_p) begin
                pacc_q.push_back(lbl);
                if (i_eop) peop_q.push_back(lbl);
            end
            prev_stall = o_val && !o_rdy;
            prev_dat   = o_dat;
            prev_eop   = o_eop;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (hs_h) begin void'(hq.pop_front()); h_on = 1'b0; end
        if (hs_p) begin void'(pq.pop_front()); p_on = 1'b0; end
        hs_h = 1'b0;
        hs_p = 1'b0;
        if (!h_on && hq.size() > 0 && $urandom_range(99) < hprob) h_on = 1'b1;
        if (!p_on && pq.size() > 0 && $urandom_range(99) < pprob) p_on = 1'b1;
        i_hval = h_on;
        if (h_on) begin i_hdr = hq[0].hdr; i_len = hq[0].len; end
        i_val = p_on;
        if (p_on) begin i_dat = pq[0][W-1:0]; i_eop = pq[0][W]; end
        case (ordy_mode)
            0:       o_rdy = 1'b1;
            1:       o_rdy = pat[pat_i % 6];
            default: o_rdy = ($urandom_range(99) < 70);
        endcase
        pat_i++;
    endtask

    task automatic add_pkt(input hdr_t h, input int npay, input logic [W-1:0] base, input bit rnd);
        logic [W:0] wd;
        hq.push_back(h);
        for (int k = 0; k <= int'(h.len); k++) exp_q.push_back({1'b0, h.hdr[k]});
        for (int k = 0; k < npay; k++) begin
            wd[W-1:0] = rnd ? W'($urandom) : base + W'(k);
            wd[W]     = (k == npay - 1);
            pq.push_back(wd);
            exp_q.push_back(wd);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin tick(); n++; end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout actual %0d words left expected 0", exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    task automatic clear_logs();
        out_cyc.delete(); hacc_q.delete(); pacc_q.delete(); peop_q.delete();
    endtask

    initial begin
        hdr_t h;
        int t, n;
        h.hdr = 32'h44332211;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_val", int'(o_val), 0);
        chk("rst_o_eop", int'(o_eop), 0);
        chk("rst_o_dat", int'(o_dat), 0);
        chk("rst_i_rdy", int'(i_rdy), 0);
        chk("rst_i_hrdy", int'(i_hrdy), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_i_hrdy", int'(i_hrdy), 1);
        chk("post_rst_o_val", int'(o_val), 0);

        // Full header, early payload, o_rdy held high.
        clear_logs();
        h.len = 2'd3;
        add_pkt(h, 2, 8'hA0, 0);
        drain();
        chk("full_nwords", out_cyc.size(), 6);
        chk("full_nhdr", hacc_q.size(), 1);
        if (out_cyc.size() == 6 && hacc_q.size() == 1) begin
            t = hacc_q[0];
            for (int k = 0; k < 6; k++) chk($sformatf("full_cyc%0d", k), out_cyc[k], t + 1 + k + LAT);
            chk("full_pay_accept", pacc_q[0], t + 5);
        end

        // Single-word header.
        clear_logs();
        h.len = 2'd0;
        add_pkt(h, 1, 8'hB0, 0);
        drain();
        chk("single_nwords", out_cyc.size(), 2);
        if (out_cyc.size() == 2 && hacc_q.size() == 1)
            chk("single_pay_cyc", out_cyc[1], hacc_q[0] + 2 + LAT);

        // Back-to-back packets with header valid held high.
        clear_logs();
        h.len = 2'd1;
        add_pkt(h, 2, 8'hC0, 0);
        h.hdr = 32'h98765432;
        h.len = 2'd2;
        add_pkt(h, 1, 8'hD0, 0);
        drain();
        chk("b2b_nwords", out_cyc.size(), 8);
        if (out_cyc.size() == 8 && hacc_q.size() == 2 && peop_q.size() == 2) begin
            chk("b2b_hdr_accept", hacc_q[1], peop_q[0] + 1);
            chk("b2b_word0_cyc", out_cyc[4], peop_q[0] + 2 + LAT);
            chk("b2b_bubble", out_cyc[4] - out_cyc[3], 2);
        end

        // Output backpressure pattern.
        clear_logs();
        h.hdr = 32'h44332211;
        h.len = 2'd3;
        ordy_mode = 1;
        pat_i = 0;
        add_pkt(h, 2, 8'hA0, 0);
        drain();
        chk("bp_nwords", out_cyc.size(), 6);

        // Reset after two header words.
        clear_logs();
        ordy_mode = 0;
        add_pkt(h, 2, 8'hE0, 0);
        n = 0;
        while (out_cyc.size() < 2 && n < 200) begin tick(); n++; end
        chk("rst_mid_reached", out_cyc.size(), 2);
        reset = 1'b1;
        hq.delete(); pq.delete(); exp_q.delete();
        h_on = 1'b0; p_on = 1'b0; hs_h = 1'b0; hs_p = 1'b0;
        i_hval = 1'b0; i_val = 1'b0;
        #1;
        chk("mid_rst_o_val", int'(o_val), 0);
        chk("mid_rst_i_hrdy", int'(i_hrdy), 0);
        chk("mid_rst_i_rdy", int'(i_rdy), 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("mid_post_i_hrdy", int'(i_hrdy), 1);
        chk("mid_post_o_val", int'(o_val), 0);
        clear_logs();
        add_pkt(h, 1, 8'hF0, 0);
        drain();
        chk("restart_nwords", out_cyc.size(), 5);

        // Randomised traffic.
        ordy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            for (int k = 0; k < L; k++) h.hdr[k] = W'($urandom);
            h.len = LW'($urandom_range(L - 1));
            add_pkt(h, $urandom_range(1, 4), '0, 1);
        end
        hprob = $urandom_range(30, 100);
        pprob = $urandom_range(30, 100);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
